// File: rtl/dino_jump_ctrl.sv
// Jump controller for the dino runner: edge-triggered take-off, rise/fall kinematics, landing pulses.
// Optional macro JUMP_BUFFER_EN remembers a press made while falling and launches on the tick after landing.
module dino_jump_ctrl #(
    parameter int Y_W      = 8,
    parameter int JUMP_VEL = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 15,
    parameter int MAX_Y    = 200
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           jump_pressed,
    input  logic           tick,
    input  logic           game_active,
    output logic [Y_W-1:0] dino_y,
    output logic           airborne,
    output logic           jump_start,
    output logic           land,
    output logic [1:0]     state_dbg
);

    localparam logic [1:0] ST_GROUND = 2'd0;
    localparam logic [1:0] ST_RISE   = 2'd1;
    localparam logic [1:0] ST_FALL   = 2'd2;

    localparam logic [Y_W-1:0] JV = Y_W'(JUMP_VEL);
    localparam logic [Y_W-1:0] GR = Y_W'(GRAVITY);
    localparam logic [Y_W-1:0] MF = Y_W'(MAX_FALL);
    localparam logic [Y_W-1:0] MY = Y_W'(MAX_Y);
    localparam logic [Y_W-1:0] TAKEOFF_Y = (JUMP_VEL < MAX_Y) ? JV : MY;

    logic [1:0]     state;
    logic [Y_W-1:0] vel;
    logic           jump_prev;
    logic           req;
    logic           buf_q;
    logic           jump_edge;
    logic           step;
    logic           launch;
    logic [Y_W:0]   rise_sum;
    logic [Y_W-1:0] rise_y;
    logic [Y_W:0]   fall_sum;
    logic [Y_W-1:0] fall_vel;

    assign jump_edge = jump_pressed & ~jump_prev;
    assign step      = tick & game_active;
    assign launch    = step && (state == ST_GROUND) && (req || jump_edge || buf_q);
    assign airborne  = (state == ST_RISE) || (state == ST_FALL);
    assign state_dbg = state;

    // Sums carry one extra bit so saturation is decided before any wrap.
    assign rise_sum = {1'b0, dino_y} + {1'b0, vel};
    assign rise_y   = (rise_sum > {1'b0, MY}) ? MY : rise_sum[Y_W-1:0];
    assign fall_sum = {1'b0, vel} + {1'b0, GR};
    assign fall_vel = (fall_sum > {1'b0, MF}) ? MF : fall_sum[Y_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_GROUND;
            dino_y     <= '0;
            vel        <= '0;
            jump_prev  <= 1'b0;
            req        <= 1'b0;
            jump_start <= 1'b0;
            land       <= 1'b0;
        end else begin
            jump_prev  <= jump_pressed;
            jump_start <= 1'b0;
            land       <= 1'b0;

            if (!game_active) begin
                req <= 1'b0;
            end else if (state == ST_GROUND) begin
                if (launch)         req <= 1'b0;
                else if (jump_edge) req <= 1'b1;
            end

            if (step) begin
                case (state)
                    ST_GROUND: begin
                        if (launch) begin
                            state      <= ST_RISE;
                            dino_y     <= TAKEOFF_Y;
                            vel        <= JV - GR;
                            jump_start <= 1'b1;
                        end
                    end
                    ST_RISE: begin
                        dino_y <= rise_y;
                        if (vel <= GR) begin
                            vel   <= '0;
                            state <= ST_FALL;
                        end else begin
                            vel <= vel - GR;
                        end
                    end
                    ST_FALL: begin
                        if (dino_y <= vel) begin
                            dino_y <= '0;
                            vel    <= '0;
                            state  <= ST_GROUND;
                            land   <= 1'b1;
                        end else begin
                            dino_y <= dino_y - vel;
                            vel    <= fall_vel;
                        end
                    end
                    default: state <= ST_GROUND;
                endcase
            end
        end
    end

`ifdef JUMP_BUFFER_EN
    // A press while falling is held until the first tick back on the ground.
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_q <= 1'b0;
        end else if (!game_active || launch) begin
            buf_q <= 1'b0;
        end else if (state == ST_FALL && jump_edge) begin
            buf_q <= 1'b1;
        end
    end
`else
    assign buf_q = 1'b0;
`endif

endmodule
